load_store_unit: RTL
====================

# load_store_unit

Memory-stage access controller sitting between the EX/MEM pipeline register and `data_memory`. It takes one load or store request per cycle, sign- or zero-extends load data, and merges sub-word stores with a read-modify-write sequence. `data_memory` only writes full 4-byte words. The unit stalls the pipeline only while a sub-word store is in flight.

## Interface
Parameters:
- `MEM_BYTES`, 120: byte size of the attached data memory; used only for the range check.

Ports:
- `clk`  input  1  rising-edge clock
- `rst_n`  input  1  synchronous, active-high reset (port name kept for codebase consistency)
- `req_valid_i`  input  1  request present this cycle
- `mem_read_i`  input  1  request is a load
- `mem_write_i`  input  1  request is a store
- `funct3_i`  input  3  RV32I width/sign code: 000 b, 001 h, 010 w, 100 bu, 101 hu
- `addr_i`  input  32  byte address
- `wdata_i`  input  32  store data (rs2)
- `mem_rdata_i`  input  32  combinational read word from `data_memory` (`data_o`)
- `mem_addr_o`  output  32  address to `data_memory`
- `mem_wdata_o`  output  32  write word
- `mem_read_o`  output  1  read enable
- `mem_write_o`  output  1  write enable
- `stall_o`  output  1  hold the request and freeze upstream stages (combinational)
- `done_o`  output  1  one-cycle pulse, registered: the previous request has completed
- `rdata_o`  output  32  extended load result, registered, valid while `done_o`=1
- `misalign_o`  output  1  one-cycle pulse, registered: the request was rejected

## Operation
- FSM states: `IDLE`, `ST_WR`.
- In `IDLE` with `req_valid_i`=1, the request is classified:
  - **Load:** `mem_read_o`=1 and `mem_addr_o`=`addr_i` in the same cycle.
  - **Load extension:** the extended low byte/half/word of `mem_rdata_i` is registered into `rdata_o`. b/h sign-extend; bu/hu zero-extend.
  - **Load completion:** `done_o`=1 next cycle, no stall.
  - **sw:** `mem_write_o`=1, `mem_wdata_o`=`wdata_i` in the same cycle. `done_o` next cycle, no stall.
  - **sb/sh:**
    - In the request cycle: `mem_read_o`=1, `stall_o`=1, and the merged word is captured. The merged word is `mem_rdata_i` with its low 8/16 bits replaced by `wdata_i[7:0]`/`[15:0]`. The FSM then moves to `ST_WR`.
    - In `ST_WR`: `mem_write_o`=1, `mem_addr_o`=held address, `mem_wdata_o`=merged word, `stall_o`=0. The FSM returns to `IDLE`, and `done_o` pulses the cycle after.
- Lane rule: extension and merge always use the low bits of the word returned at `addr_i`, because `data_memory` returns bytes `addr..addr+3` with `addr` in the LSB position.
- Requests arriving while in `ST_WR` are ignored (they are the held copy).
- Boundary cases:
  - **Both enables set:** when `mem_read_i` and `mem_write_i` are both 1, the request is treated as a store.
  - **Neither enable set:** nothing happens.
  - **Illegal funct3 (011/110/111):** no memory access; `done_o` pulses, `rdata_o`=0.
  - **Range error:** when `addr_i+3 >= MEM_BYTES`, there is no memory access. `done_o` pulses with `rdata_o`=0 and `misalign_o`=1.
- Reset, including mid-RMW: the FSM returns to `IDLE` and any pending write is abandoned. All registered outputs clear to 0, and combinational outputs are 0 in `IDLE` with no request.

## Timing
- Load latency: 1 cycle (`rdata_o` and `done_o` at N+1).
- sw latency: 1 cycle.
- sb/sh latency: 2 cycles, with exactly one stall cycle. The write occurs at the end of cycle N+1 and `done_o` pulses at N+2.
- Back-to-back: a new request is accepted in any `IDLE` cycle, including the cycle in which `done_o` is high.
- Throughput: 1 request/cycle for lw/sw and loads; 1 request per 2 cycles for sb/sh.

## Configuration
- Macro: `LSU_MISALIGN_TRAP_EN`.
- **Defined:** these requests are misaligned:
  - lw/sw with `addr_i[1:0]`≠0;
  - lh/lhu/sh with `addr_i[0]`≠0.

  A misaligned request gets no memory access and no stall. The next cycle, `misalign_o`=1, `done_o`=1 and `rdata_o`=0.
- **Undefined:** misaligned requests proceed normally (byte-addressed memory tolerates them), and `misalign_o` is tied 0 except for the range error.

## Structure
- Package `lsu_pkg`:
  - funct3 localparams `F3_LB`…`F3_LHU`;
  - state enum `lsu_state_e` {`IDLE`, `ST_WR`};
  - function `is_misaligned(funct3, addr)`.
- One sub-module, `load_store_align`: purely combinational load extension and store merge, instantiated once. The FSM and output registers stay in `load_store_unit`.

## Test plan
Memory preload: bytes [0x10..0x13] = BB,AA,99,88 and [0x14]=77.
- lb at 0x10 → `rdata_o`=0xFFFFFFBB at N+1; lbu at 0x10 → 0x000000BB; lb at 0x11 → 0xFFFFFFAA; lhu at 0x12 → 0x00008899.
- sb at 0x12 with `wdata_i`=0x11223344 → one stall cycle, write at N+1, `done_o` at N+2. Word at 0x10 reads 0x8844AABB and byte 0x14 is still 0x77.
- sh at 0x10 with 0x0000CAFE → word at 0x10 = 0x8899CAFE. sw at 0x10 with 0xDEADBEEF → 0xDEADBEEF with no stall.
- sw at 0x11:
  - with `LSU_MISALIGN_TRAP_EN`: `misalign_o`=1 at N+1, no `mem_write_o`, memory unchanged;
  - without it: bytes 0x11..0x14 are written.
- sb at 0x12 with reset asserted during the `ST_WR` cycle → `mem_write_o` stays 0 after reset, memory unchanged, FSM in `IDLE`, all outputs 0.
- lw at 0x10 followed immediately by sb at 0x14 → lw `done_o` with no stall; sb stalls exactly one cycle; `done_o` pulses twice in total.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, FSM state type and alignment helper for load_store_unit
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        IDLE  = 1'b0,
        ST_WR = 1'b1
    } lsu_state_e;

    // Width comes from funct3[1:0] for both loads and stores: 00 byte, 01 half, 10 word.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr);
        case (funct3[1:0])
            2'b10:   is_misaligned = (addr != 2'b00);
            2'b01:   is_misaligned = addr[0];
            default: is_misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic is_legal_funct3(input logic [2:0] funct3);
        is_legal_funct3 = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
    endfunction

endpackage

// File: rtl/load_store_align.sv
// rtl/load_store_align.sv - combinational load extension and sub-word store merge on the low lanes
module load_store_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] rdata,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    // data_memory returns the addressed byte in the LSB, so only low lanes are ever used.
    always_comb begin
        load_data = '0;
        case (funct3)
            F3_LB:   load_data = {{24{rdata[7]}}, rdata[7:0]};
            F3_LH:   load_data = {{16{rdata[15]}}, rdata[15:0]};
            F3_LW:   load_data = rdata;
            F3_LBU:  load_data = {24'd0, rdata[7:0]};
            F3_LHU:  load_data = {16'd0, rdata[15:0]};
            default: load_data = '0;
        endcase
    end

    always_comb begin
        merged_word = rdata;
        if (funct3[0]) begin
            merged_word[15:0] = wdata;
        end else begin
            merged_word[7:0] = wdata[7:0];
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-stage load/store controller with sub-word RMW; option LSU_MISALIGN_TRAP_EN
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = 120
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] mem_rdata_i,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);

    lsu_state_e  state_q, state_d;
    logic [31:0] addr_q;
    logic [31:0] merge_q;
    logic [31:0] load_data;
    logic [31:0] merged_word;

    logic is_store;
    logic is_load;
    logic accept;
    logic f3_ok;
    logic in_range;
    logic trap;
    logic go;
    logic sub_word;

    load_store_align u_align (
        .funct3      (funct3_i),
        .rdata       (mem_rdata_i),
        .wdata       (wdata_i[15:0]),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    // A request with both enables set is a store.
    assign is_store = mem_write_i;
    assign is_load  = mem_read_i & ~mem_write_i;
    assign accept   = req_valid_i & (mem_read_i | mem_write_i) & (state_q == IDLE);
    assign f3_ok    = is_legal_funct3(funct3_i);
    assign in_range = ({1'b0, addr_i} + 33'd3) < 33'(MEM_BYTES);
`ifdef LSU_MISALIGN_TRAP_EN
    assign trap     = is_misaligned(funct3_i, addr_i[1:0]);
`else
    assign trap     = 1'b0;
`endif
    assign go       = accept & f3_ok & in_range & ~trap;
    assign sub_word = (funct3_i[1:0] != 2'b10);

    // rst_n is active-high; it also gates the memory strobes so a pending RMW write is dropped.
    always_comb begin
        state_d     = state_q;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_read_o  = 1'b0;
        mem_write_o = 1'b0;
        stall_o     = 1'b0;
        if (rst_n) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (go) begin
                        mem_addr_o = addr_i;
                        if (is_store && sub_word) begin
                            mem_read_o = 1'b1;
                            stall_o    = 1'b1;
                            state_d    = ST_WR;
                        end else if (is_store) begin
                            mem_write_o = 1'b1;
                            mem_wdata_o = wdata_i;
                        end else begin
                            mem_read_o = 1'b1;
                        end
                    end
                end
                ST_WR: begin
                    mem_addr_o  = addr_q;
                    mem_wdata_o = merge_q;
                    mem_write_o = 1'b1;
                    state_d     = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            merge_q    <= '0;
            done_o     <= 1'b0;
            rdata_o    <= '0;
            misalign_o <= 1'b0;
        end else begin
            state_q    <= state_d;
            done_o     <= 1'b0;
            rdata_o    <= '0;
            misalign_o <= 1'b0;
            if (state_q == ST_WR) begin
                done_o <= 1'b1;
            end else if (accept) begin
                if (!f3_ok) begin
                    done_o <= 1'b1;
                end else if (!in_range || trap) begin
                    done_o     <= 1'b1;
                    misalign_o <= 1'b1;
                end else if (is_load) begin
                    done_o  <= 1'b1;
                    rdata_o <= load_data;
                end else if (!sub_word) begin
                    done_o <= 1'b1;
                end else begin
                    addr_q  <= addr_i;
                    merge_q <= merged_word;
                end
            end
        end
    end

    logic unused_is_load;
    assign unused_is_load = is_load & 1'b0;

endmodule
